booth_seq_divider: RTL
======================

// Module: booth_seq_divider
// PURPOSE
//  Sequential signed divider, the inverse of the team's 4-bit Booth multiplier.
//  Takes a 2W-bit signed dividend, typically a multiplier product, and a W-bit signed divisor.
//  Returns a W-bit quotient and a W-bit remainder using restoring division, one bit per clock.
//  Driven by the tile's ui_in/uio wrapper through a start/busy/done handshake.
// PARAMETERS
//  W   4   operand width; dividend is 2W bits, divisor/quotient/remainder are W bits
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  start      in   1    begin a division; sampled only when busy=0
//  dividend   in   2W   signed two's-complement dividend
//  divisor    in   W    signed two's-complement divisor
//  busy       out  1    operation in progress
//  done       out  1    one-cycle pulse: results valid from this cycle
//  quotient   out  W    signed quotient, truncated toward zero
//  remainder  out  W    signed remainder; sign follows dividend
//  ovf        out  1    quotient not representable in W signed bits
//  dbz        out  1    divisor was zero
// BEHAVIOUR
//  - Clock/reset: one clock; reset is asynchronous and active-high.
//  - Reset values: state=IDLE, busy=0, done=0; quotient, remainder, ovf, dbz all 0.
//  - FSM states: IDLE, CALC, FIX.
//    - IDLE: on start, latch |dividend| (2W bits), |divisor| (W+1 bits) and both signs.
//      - Divisor == 0 -> FIX directly.
//      - Otherwise -> CALC with the iteration counter set to 2W-1.
//    - CALC: shift the {rem,quo} register left by 1 and trial-subtract |divisor|.
//      - Result >= 0: keep it, quotient bit = 1. Otherwise restore, quotient bit = 0.
//      - Counter == 0 -> FIX; otherwise decrement the counter.
//    - FIX: apply signs, register all outputs, assert done, then return to IDLE.
//  - busy=1 in CALC and FIX. done=1 only in the cycle after the FIX edge.
//  - Latency, counted from the edge that samples start to the first cycle with done=1:
//    - 2W+1 edges for a normal division (9 for W=4).
//    - 1 edge for a zero divisor.
//  - Sign fixup:
//    - Quotient is negated when the dividend and divisor signs differ.
//    - Remainder is negated when the dividend is negative.
//    - |remainder| < |divisor| <= 2^(W-1), so the remainder always fits.
//  - ovf: signed quotient outside [-2^(W-1), 2^(W-1)-1].
//    - quotient saturates to 2^(W-1)-1 or -2^(W-1) by sign; remainder is the true value.
//  - dbz: quotient = all ones, remainder = dividend[W-1:0], ovf = 0.
//  - Outputs (quotient/remainder/ovf/dbz) hold until the next FIX. done is 0 otherwise.
//  - start while busy=1 is ignored; operands are not re-latched. start=1 in the done cycle
//    (state IDLE) is accepted, so back-to-back operation is supported.
//  - Operand inputs may change freely after the start edge.
//  - The most negative dividend (-2^(2W-1)) is handled: its magnitude fits 2W unsigned bits.
//  - Reset asserted mid-operation aborts to IDLE with all outputs at reset values. No done.
// STRUCTURE
//  - Shared package booth_pkg: W default, FSM state enum {IDLE,CALC,FIX}, counter width
//    $clog2(2W).
//  - One sub-module: booth_sign_mag, a combinational abs/negate helper (value -> magnitude,
//    sign). Reused for operand capture and for result fixup.
// TESTING  (W=4)
//  1. dividend=35, divisor=5, start -> done 9 cycles later; quotient=7, remainder=0,
//     ovf=0, dbz=0.
//  2. dividend=-35, divisor=4 -> quotient=-8 (4'h8), remainder=-3 (4'hD), ovf=0.
//     Also 21/-4 -> quotient=-5, remainder=1.
//  3. dividend=64, divisor=2 -> ovf=1, quotient=7; dividend=-128, divisor=-8 -> ovf=1,
//     quotient=7, remainder=0.
//  4. dividend=8'h10, divisor=0 -> done after 1 cycle; dbz=1, quotient=4'hF, remainder=0.
//  5. Start a division, pulse start again with new operands at cycle 3 -> ignored; first
//     result only. Then assert start in the done cycle -> second result 9 cycles later.
//  6. Assert rst at cycle 4 of a division -> busy=0, outputs 0, no done pulse. After
//     release, a new division completes correctly.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier/divider tile.
package booth_pkg;

  localparam int unsigned W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Iteration counter width for a 2w-bit dividend.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(2 * w);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(W_DEF);

endpackage

// File: rtl/booth_sign_mag.sv
// Combinational two's-complement helper: conditionally negates a value and
// reports its sign bit. With neg_i tied to the sign bit this yields |value|.
module booth_sign_mag #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] val_i,
  input  logic         neg_i,
  output logic [N-1:0] mag_o,
  output logic         sign_o
);

  // Negate on request; the sign is simply the top bit of the input.
  always_comb begin
    sign_o = val_i[N-1];
    mag_o  = neg_i ? (N'(0) - val_i) : val_i;
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module booth_seq_divider
  import booth_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);

  localparam int unsigned    CW   = cnt_width(W);
  localparam logic [2*W-1:0] QLIM = (2*W)'(2 ** (W - 1));

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [2*W-1:0] quo_q, quo_d;
  logic [W:0]     dvs_q, dvs_d;
  logic           sdvd_q, sdvd_d;
  logic           sdvs_q, sdvs_d;
  logic [W-1:0]   dlo_q, dlo_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;
  logic           done_q, done_d;

  logic [2*W-1:0] dvd_mag;
  logic           dvd_sign;
  logic [W:0]     dvs_mag;
  logic           dvs_sign;
  logic [2*W-1:0] quo_fix;
  logic [W-1:0]   rem_fix;
  logic           q_sign_unused, r_sign_unused;
  logic [W:0]     shl;
  logic [W+1:0]   trial;
  logic           q_neg, q_ovf;
  logic           unused_bits;

  booth_sign_mag #(.N(2*W)) u_dvd_abs (
    .val_i  (dividend),
    .neg_i  (dividend[2*W-1]),
    .mag_o  (dvd_mag),
    .sign_o (dvd_sign)
  );

  booth_sign_mag #(.N(W+1)) u_dvs_abs (
    .val_i  ({divisor[W-1], divisor}),
    .neg_i  (divisor[W-1]),
    .mag_o  (dvs_mag),
    .sign_o (dvs_sign)
  );

  booth_sign_mag #(.N(2*W)) u_quo_fix (
    .val_i  (quo_q),
    .neg_i  (q_neg),
    .mag_o  (quo_fix),
    .sign_o (q_sign_unused)
  );

  booth_sign_mag #(.N(W)) u_rem_fix (
    .val_i  (rem_q),
    .neg_i  (sdvd_q),
    .mag_o  (rem_fix),
    .sign_o (r_sign_unused)
  );

  // The partial remainder stays below |divisor| <= 2^(W-1), so trial[W] and the
  // upper half of the fixed-up quotient carry no information.
  assign unused_bits = ^{q_sign_unused, r_sign_unused, trial[W], quo_fix[2*W-1:W]};

  // Next-state, datapath and result computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sdvd_d      = sdvd_q;
    sdvs_d      = sdvs_q;
    dlo_d       = dlo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    shl   = {rem_q, quo_q[2*W-1]};
    trial = {1'b0, shl} - {1'b0, dvs_q};
    q_neg = sdvd_q ^ sdvs_q;
    // A negative quotient may reach -2^(W-1); a positive one only 2^(W-1)-1.
    q_ovf = q_neg ? (quo_q > QLIM) : (quo_q >= QLIM);

    case (state_q)
      IDLE: begin
        if (start) begin
          sdvd_d  = dvd_sign;
          sdvs_d  = dvs_sign;
          dvs_d   = dvs_mag;
          quo_d   = dvd_mag;
          rem_d   = '0;
          dlo_d   = dividend[W-1:0];
          cnt_d   = CW'(2 * W - 1);
          state_d = (dvs_mag == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (!trial[W+1]) begin
          rem_d = trial[W-1:0];
          quo_d = {quo_q[2*W-2:0], 1'b1};
        end else begin
          rem_d = shl[W-1:0];
          quo_d = {quo_q[2*W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = dlo_q;
          ovf_d       = 1'b0;
          dbz_d       = 1'b1;
        end else begin
          remainder_d = rem_fix;
          ovf_d       = q_ovf;
          dbz_d       = 1'b0;
          if (q_ovf) begin
            quotient_d = q_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end else begin
            quotient_d = quo_fix[W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sdvd_q      <= 1'b0;
      sdvs_q      <= 1'b0;
      dlo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sdvd_q      <= sdvd_d;
      sdvs_q      <= sdvs_d;
      dlo_q       <= dlo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule
